// File: rtl/mips_cpu_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_cpu_mem_pkg
// Description : Shared types and helpers for the MIPS load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_cpu_mem_pkg;

  // Access size as encoded on the core's req_size field
  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_FULL = 2'b11
  } size_t;

  // Load/store sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS   = 2'd1,
    RDATA = 2'd2,
    RESP  = 2'd3
  } mem_state_t;

  // Number of bytes touched by an access of the given size on an nbytes-wide bus
  function automatic logic [3:0] size_bytes(input size_t size, input int nbytes);
    case (size)
      SIZE_BYTE: return 4'd1;
      SIZE_HALF: return 4'd2;
      SIZE_WORD: return 4'd4;
      default:   return 4'(nbytes);
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_cpu_mem_lane.sv
`default_nettype none
// ============================================================================
// Module      : mips_cpu_mem_lane
// Description : Combinational byte-lane logic: byteenable generation, store
//               data replication and load data extract / extend.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_cpu_mem_lane
  import mips_cpu_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]                       size_i,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]  lane_i,
  input  logic                             signed_i,
  input  logic [DATA_WIDTH-1:0]            wdata_i,
  input  logic [DATA_WIDTH-1:0]            rdata_i,
  output logic [DATA_WIDTH/8-1:0]          be_o,
  output logic [DATA_WIDTH-1:0]            wdata_o,
  output logic [DATA_WIDTH-1:0]            rdata_o
);
  localparam int NBYTES = DATA_WIDTH / 8;

  size_t                  w_size;
  logic [NBYTES-1:0]      w_mask;
  logic [DATA_WIDTH-1:0]  w_shift;
  logic [DATA_WIDTH-1:0]  w_keep;
  logic                   w_sign;

  assign w_size = size_t'(size_i);

  // Size-wide enable mask and store data copied onto every lane of that size
  always_comb begin
    w_mask  = '1;
    wdata_o = wdata_i;
    case (w_size)
      SIZE_BYTE: begin
        w_mask  = NBYTES'(1);
        wdata_o = {NBYTES{wdata_i[7:0]}};
      end
      SIZE_HALF: begin
        w_mask  = NBYTES'(3);
        wdata_o = {(NBYTES/2){wdata_i[15:0]}};
      end
      SIZE_WORD: begin
        w_mask  = NBYTES'(15);
        wdata_o = {(NBYTES/4){wdata_i[31:0]}};
      end
      default: ;
    endcase
  end

  assign be_o    = w_mask << lane_i;
  assign w_shift = rdata_i >> {lane_i, 3'b000};

  // Keep mask and sign bit for the loaded item; full width needs no extension
  always_comb begin
    w_keep = '1;
    w_sign = 1'b0;
    case (w_size)
      SIZE_BYTE: begin
        w_keep = DATA_WIDTH'(8'hFF);
        w_sign = signed_i & w_shift[7];
      end
      SIZE_HALF: begin
        w_keep = DATA_WIDTH'(16'hFFFF);
        w_sign = signed_i & w_shift[15];
      end
      SIZE_WORD: begin
        w_keep = DATA_WIDTH'(32'hFFFF_FFFF);
        w_sign = signed_i & w_shift[31];
      end
      default: ;
    endcase
  end

  assign rdata_o = (w_shift & w_keep) | ({DATA_WIDTH{w_sign}} & ~w_keep);

endmodule
`default_nettype wire

// File: rtl/mips_cpu_mem_access.sv
`default_nettype none
// ============================================================================
// Module      : mips_cpu_mem_access
// Description : Load/store unit bridging the multicycle MIPS core to an
//               Avalon-MM master port. Byte/half/word/full-width accesses,
//               lane steering, sign/zero extension, waitrequest handling.
//               Optional macro MIPS_MEM_MISALIGN_CHECK_EN: misaligned
//               requests are answered with resp_error and no bus access;
//               otherwise the offending low address bits are cleared.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_cpu_mem_access
  import mips_cpu_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [1:0]              req_size,
  input  logic                    req_signed,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_error,
  output logic [ADDR_WIDTH-1:0]   address,
  output logic                    read,
  output logic                    write,
  input  logic                    waitrequest,
  output logic [DATA_WIDTH-1:0]   writedata,
  output logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic [DATA_WIDTH-1:0]   readdata
);
  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int LANE_W = $clog2(NBYTES);

  mem_state_t             state_q, state_d;
  logic                   write_q;
  logic [1:0]             size_q;
  logic                   signed_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic                   error_q;

  logic                   w_accept;
  logic                   w_err;
  logic                   w_in_bus;
  logic [LANE_W-1:0]      w_lo_mask;
  logic [ADDR_WIDTH-1:0]  w_addr_aligned;
  logic [NBYTES-1:0]      w_be;
  logic [DATA_WIDTH-1:0]  w_wdata_rep;
  logic [DATA_WIDTH-1:0]  w_ld_data;

  assign req_ready = (state_q == IDLE) || (state_q == RESP);
  assign w_accept  = req_valid && req_ready;

  // Low address bits that must be zero for an access of the requested size
  assign w_lo_mask      = LANE_W'(size_bytes(size_t'(req_size), NBYTES) - 4'd1);
  assign w_addr_aligned = {req_addr[ADDR_WIDTH-1:LANE_W], req_addr[LANE_W-1:0] & ~w_lo_mask};

`ifdef MIPS_MEM_MISALIGN_CHECK_EN
  assign w_err = |(req_addr[LANE_W-1:0] & w_lo_mask);
`else
  assign w_err = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode; RESP doubles as an accept slot for back-to-back requests
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RESP: begin
        if (w_accept) state_d = w_err ? RESP : BUS;
        else          state_d = IDLE;
      end
      BUS: begin
        if (!waitrequest) state_d = write_q ? RESP : RDATA;
      end
      RDATA:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  // Request capture on accept and load data capture in RDATA
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_q  <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      error_q  <= 1'b0;
    end else if (w_accept) begin
      write_q  <= req_write;
      size_q   <= req_size;
      signed_q <= req_signed;
      addr_q   <= w_addr_aligned;
      wdata_q  <= req_wdata;
      rdata_q  <= '0;
      error_q  <= w_err;
    end else if (state_q == RDATA) begin
      rdata_q  <= w_ld_data;
    end
  end

  mips_cpu_mem_lane #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lane (
    .size_i   (size_q),
    .lane_i   (addr_q[LANE_W-1:0]),
    .signed_i (signed_q),
    .wdata_i  (wdata_q),
    .rdata_i  (readdata),
    .be_o     (w_be),
    .wdata_o  (w_wdata_rep),
    .rdata_o  (w_ld_data)
  );

  // Bus outputs are driven only while in BUS, idle at zero otherwise
  assign w_in_bus   = (state_q == BUS);
  assign read       = w_in_bus & ~write_q;
  assign write      = w_in_bus & write_q;
  assign address    = w_in_bus ? {addr_q[ADDR_WIDTH-1:LANE_W], LANE_W'(0)} : '0;
  assign byteenable = w_in_bus ? w_be : '0;
  assign writedata  = w_in_bus ? w_wdata_rep : '0;

  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_error = error_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_mem_access.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_cpu_mem_access
// Description : Self-checking bench for mips_cpu_mem_access (32-bit bus).
//               Expected responses are queued at issue and popped on
//               resp_valid; per-test tasks check bus shape and latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_cpu_mem_access;
  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid, req_ready, req_write, req_signed;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid, resp_error;
  logic [DW-1:0] resp_rdata;
  logic [AW-1:0] address;
  logic          read, write;
  logic          waitrequest = 1'b0;
  logic [DW-1:0] writedata;
  logic [3:0]    byteenable;
  logic [DW-1:0] readdata = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          waits_cfg = 0;
  logic [31:0] rd_cfg = 32'h0;
  int          wcnt = 0;
  logic        rd_pending = 1'b0;

  always #5 clk = ~clk;

  mips_cpu_mem_access #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_error  (resp_error),
    .address     (address),
    .read        (read),
    .write       (write),
    .waitrequest (waitrequest),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .readdata    (readdata)
  );

  // Avalon slave model: waits_cfg wait states per access, readdata valid only
  // in the cycle after a read is accepted (garbage otherwise)
  always @(negedge clk) begin
    readdata   = rd_pending ? rd_cfg : 32'hDEAD_BEEF;
    rd_pending = 1'b0;
    if (read || write) begin
      if (wcnt < waits_cfg) begin
        waitrequest = 1'b1;
        wcnt++;
      end else begin
        waitrequest = 1'b0;
        wcnt = 0;
        rd_pending = read;
      end
    end else begin
      waitrequest = 1'b0;
      wcnt = 0;
    end
  end

  // Scoreboard: every response must match the oldest outstanding expectation
  always @(negedge clk) begin : b_sb
    exp_t e;
    if (resp_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL resp_unexpected: got rdata=%h err=%b, required no response", resp_rdata, resp_error);
      end else begin
        e = exp_q.pop_front();
        if ({resp_rdata, resp_error} !== {e.rdata, e.err}) begin
          bad++;
          $display("FAIL resp_data: got rdata=%h err=%b, required rdata=%h err=%b",
                   resp_rdata, resp_error, e.rdata, e.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Present one request at a negedge; returns at the negedge after acceptance
  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                       input logic [31:0] wd, input logic push, input logic [31:0] er, input logic ee);
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    if (push) exp_q.push_back({er, ee});
    @(negedge clk);
    req_valid  = 1'b0;
    req_wdata  = 32'h0BAD_0BAD;
    req_addr   = 32'hFFFF_FFFF;
  endtask

  // Walk cycles E0+1.. until resp_valid, recording bus activity
  task automatic observe(input int max, output int lat, output int nbus, output logic [31:0] a0,
                         output logic [3:0] be0, output logic [31:0] wd0, output logic stable);
    lat = -1; nbus = 0; a0 = '0; be0 = '0; wd0 = '0; stable = 1'b1;
    for (int k = 1; k <= max; k++) begin
      if (read || write) begin
        if (nbus == 0) begin
          a0 = address; be0 = byteenable; wd0 = writedata;
        end else if ({address, byteenable, writedata} !== {a0, be0, wd0}) begin
          stable = 1'b0;
        end
        nbus++;
      end
      if (resp_valid === 1'b1) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    total++;
    if ({req_ready, read, write, resp_valid, resp_error} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_ctrl: got ready/rd/wr/rv/err=%b, required 10000",
               {req_ready, read, write, resp_valid, resp_error});
    end
    total++;
    if ({address, writedata, byteenable, resp_rdata} !== 100'h0) begin
      bad++;
      $display("FAIL reset_data: got addr=%h wd=%h be=%b rdata=%h, required all zero",
               address, writedata, byteenable, resp_rdata);
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({req_ready, read, write, resp_valid} !== 4'b1000) begin
      bad++;
      $display("FAIL post_reset_idle: got %b, required 1000", {req_ready, read, write, resp_valid});
    end
  endtask

  task automatic test_sb();
    int lat, nb; logic [31:0] a0, wd0; logic [3:0] be0; logic st;
    waits_cfg = 0;
    issue(1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00A5, 1'b1, 32'h0, 1'b0);
    observe(20, lat, nb, a0, be0, wd0, st);
    total++;
    if ({a0, be0, wd0} !== {32'h0000_1000, 4'b1000, 32'hA5A5_A5A5}) begin
      bad++;
      $display("FAIL sb_bus: got addr=%h be=%b wd=%h, required 00001000 1000 a5a5a5a5", a0, be0, wd0);
    end
    total++;
    if (nb != 1 || lat != 2) begin
      bad++;
      $display("FAIL sb_timing: got write_cycles=%0d lat=%0d, required 1 and 2", nb, lat);
    end
  endtask

  task automatic test_loads();
    int lat, nb; logic [31:0] a0, wd0; logic [3:0] be0; logic st;
    logic [31:0] addrs [4] = '{32'h0000_2002, 32'h0000_2002, 32'h0000_3001, 32'h0000_3000};
    logic [31:0] rds   [4] = '{32'h8001_1234, 32'h8001_1234, 32'h1234_56F0, 32'h1234_56F0};
    logic [1:0]  szs   [4] = '{2'b01, 2'b01, 2'b00, 2'b00};
    logic        sgs   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] exps  [4] = '{32'hFFFF_8001, 32'h0000_8001, 32'h0000_0056, 32'hFFFF_FFF0};
    logic [3:0]  bes   [4] = '{4'b1100, 4'b1100, 4'b0010, 4'b0001};
    waits_cfg = 0;
    for (int i = 0; i < 4; i++) begin
      rd_cfg = rds[i];
      issue(1'b0, szs[i], sgs[i], addrs[i], 32'h0, 1'b1, exps[i], 1'b0);
      observe(20, lat, nb, a0, be0, wd0, st);
      total++;
      if ({a0, be0} !== {addrs[i] & 32'hFFFF_FFFC, bes[i]} || nb != 1 || lat != 3) begin
        bad++;
        $display("FAIL load%0d_bus: got addr=%h be=%b rd_cycles=%0d lat=%0d, required addr=%h be=%b 1 3",
                 i, a0, be0, nb, lat, addrs[i] & 32'hFFFF_FFFC, bes[i]);
      end
    end
  endtask

  task automatic test_waits();
    int lat, nb; logic [31:0] a0, wd0; logic [3:0] be0; logic st;
    waits_cfg = 3;
    rd_cfg = 32'h1357_9BDF;
    issue(1'b0, 2'b10, 1'b1, 32'h0000_5000, 32'h0, 1'b1, 32'h1357_9BDF, 1'b0);
    observe(30, lat, nb, a0, be0, wd0, st);
    total++;
    if (nb != 4 || lat != 6 || st !== 1'b1 || a0 !== 32'h0000_5000 || be0 !== 4'b1111) begin
      bad++;
      $display("FAIL lw_wait: got rd_cycles=%0d lat=%0d stable=%b addr=%h be=%b, required 4 6 1 00005000 1111",
               nb, lat, st, a0, be0);
    end
    waits_cfg = 1;
    issue(1'b1, 2'b01, 1'b0, 32'h0000_6002, 32'h1234_BEEF, 1'b1, 32'h0, 1'b0);
    observe(30, lat, nb, a0, be0, wd0, st);
    total++;
    if (nb != 2 || lat != 3 || st !== 1'b1 || {be0, wd0} !== {4'b1100, 32'hBEEF_BEEF}) begin
      bad++;
      $display("FAIL sh_wait: got wr_cycles=%0d lat=%0d stable=%b be=%b wd=%h, required 2 3 1 1100 beefbeef",
               nb, lat, st, be0, wd0);
    end
    waits_cfg = 0;
    rd_cfg = 32'h89AB_CDEF;
    issue(1'b0, 2'b11, 1'b1, 32'h0000_9000, 32'h0, 1'b1, 32'h89AB_CDEF, 1'b0);
    observe(30, lat, nb, a0, be0, wd0, st);
    total++;
    if (nb != 1 || lat != 3 || be0 !== 4'b1111) begin
      bad++;
      $display("FAIL full_load: got rd_cycles=%0d lat=%0d be=%b, required 1 3 1111", nb, lat, be0);
    end
  endtask

  task automatic test_misalign();
    int lat, nb; logic [31:0] a0, wd0; logic [3:0] be0; logic st;
    waits_cfg = 0;
`ifdef MIPS_MEM_MISALIGN_CHECK_EN
    issue(1'b0, 2'b10, 1'b0, 32'h0000_4002, 32'h0, 1'b1, 32'h0, 1'b1);
    observe(20, lat, nb, a0, be0, wd0, st);
    total++;
    if (nb != 0 || lat != 1) begin
      bad++;
      $display("FAIL misalign_lw: got bus_cycles=%0d lat=%0d, required 0 1", nb, lat);
    end
    issue(1'b1, 2'b01, 1'b0, 32'h0000_4003, 32'h1234, 1'b1, 32'h0, 1'b1);
    observe(20, lat, nb, a0, be0, wd0, st);
    total++;
    if (nb != 0 || lat != 1) begin
      bad++;
      $display("FAIL misalign_sh: got bus_cycles=%0d lat=%0d, required 0 1", nb, lat);
    end
`else
    rd_cfg = 32'hCAFE_F00D;
    issue(1'b0, 2'b10, 1'b0, 32'h0000_4002, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0);
    observe(20, lat, nb, a0, be0, wd0, st);
    total++;
    if ({a0, be0} !== {32'h0000_4000, 4'b1111} || lat != 3) begin
      bad++;
      $display("FAIL misalign_lw: got addr=%h be=%b lat=%0d, required 00004000 1111 3", a0, be0, lat);
    end
    rd_cfg = 32'h8001_1234;
    issue(1'b0, 2'b01, 1'b1, 32'h0000_4003, 32'h0, 1'b1, 32'hFFFF_8001, 1'b0);
    observe(20, lat, nb, a0, be0, wd0, st);
    total++;
    if ({a0, be0} !== {32'h0000_4000, 4'b1100} || lat != 3) begin
      bad++;
      $display("FAIL misalign_lh: got addr=%h be=%b lat=%0d, required 00004000 1100 3", a0, be0, lat);
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic seen;
    waits_cfg = 5;
    issue(1'b0, 2'b10, 1'b0, 32'h0000_8000, 32'h0, 1'b0, 32'h0, 1'b0);
    total++;
    if (read !== 1'b1) begin
      bad++;
      $display("FAIL mid_read_active: got read=%b, required 1", read);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({read, write, req_ready, address, byteenable} !== {3'b001, 32'h0, 4'h0}) begin
      bad++;
      $display("FAIL mid_reset_async: got rd=%b wr=%b ready=%b addr=%h be=%b, required 0 0 1 0 0",
               read, write, req_ready, address, byteenable);
    end
    @(negedge clk);
    reset = 1'b0;
    waits_cfg = 0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || read !== 1'b0 || write !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL mid_reset_drop: got activity after reset, required none");
    end
  endtask

  task automatic test_back_to_back();
    int lat, nb; logic [31:0] a0, wd0; logic [3:0] be0; logic st;
    waits_cfg = 0;
    rd_cfg = 32'h5566_7788;
    issue(1'b1, 2'b10, 1'b0, 32'h0000_7000, 32'h1122_3344, 1'b1, 32'h0, 1'b0);
    observe(20, lat, nb, a0, be0, wd0, st);
    total++;
    if (nb != 1 || lat != 2 || {be0, wd0} !== {4'b1111, 32'h1122_3344}) begin
      bad++;
      $display("FAIL b2b_sw: got wr_cycles=%0d lat=%0d be=%b wd=%h, required 1 2 1111 11223344", nb, lat, be0, wd0);
    end
    total++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b1) begin
      bad++;
      $display("FAIL b2b_ready_in_resp: got ready=%b rv=%b, required 1 1", req_ready, resp_valid);
    end
    issue(1'b0, 2'b10, 1'b0, 32'h0000_7004, 32'h0, 1'b1, 32'h5566_7788, 1'b0);
    total++;
    if (read !== 1'b1 || address !== 32'h0000_7004) begin
      bad++;
      $display("FAIL b2b_no_bubble: got read=%b addr=%h, required 1 00007004", read, address);
    end
    observe(20, lat, nb, a0, be0, wd0, st);
    total++;
    if (nb != 1 || lat != 3) begin
      bad++;
      $display("FAIL b2b_lw: got rd_cycles=%0d lat=%0d, required 1 3", nb, lat);
    end
    @(negedge clk);
  endtask

  initial begin
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_sb();
    test_loads();
    test_waits();
    test_misalign();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d outstanding, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
